// File: rtl/bank_wl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bank_wl_sequencer
//  Purpose  : Initiator side of the bank word-line interface. Steps through
//             a burst of rows and, for each row, runs three phases: select
//             setup, word-line pulse and recovery. The decoder registers
//             `sel` on an edge and then gates with `WL_enable`, so `sel`
//             stays frozen from one edge before the pulse until RECOV_CYC
//             cycles after it.
//  Revision : 1.0 - initial release
// ============================================================================
module bank_wl_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] sel,
  output logic              WL_enable,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_row,
  output logic              done,
  output logic              aborted
);

  // The phase counter only has to reach the longest phase length minus one.
  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > RECOV_CYC) ? SETUP_CYC : RECOV_CYC)
                         : ((PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    RECOV = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [ADDR_W-1:0]   rows_left;
  // Remembers that this burst was cut short, so the final `done` reports it.
  logic                abort_seen;

  // cur_row is simply the registered select, exported under a second name.
  assign cur_row = sel;

  // Sequencer FSM: all outputs are registered here, none depend combinationally on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      rows_left  <= '0;
      abort_seen <= 1'b0;
      sel        <= '0;
      WL_enable  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      // done/aborted are single-cycle strobes.
      done    <= 1'b0;
      aborted <= 1'b0;

      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          WL_enable <= 1'b0;
          // req_ready is itself registered, so the first edge after reset never accepts.
          if (req_valid && req_ready) begin
            sel        <= req_row;
            rows_left  <= req_len;
            phase_cnt  <= '0;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            state      <= SETUP;
          end
        end

        SETUP: begin
          if (abort) begin
            // Word line is already low; still run a full recovery before ending.
            rows_left  <= '0;
            abort_seen <= 1'b1;
            phase_cnt  <= '0;
            state      <= RECOV;
          end else if (phase_cnt == SETUP_LAST) begin
            phase_cnt <= '0;
            WL_enable <= 1'b1;
            state     <= PULSE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        PULSE: begin
          if (abort) begin
            // Drop the word line at once but keep sel frozen through recovery.
            WL_enable  <= 1'b0;
            rows_left  <= '0;
            abort_seen <= 1'b1;
            phase_cnt  <= '0;
            state      <= RECOV;
          end else if (phase_cnt == PULSE_LAST) begin
            phase_cnt <= '0;
            WL_enable <= 1'b0;
            state     <= RECOV;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        RECOV: begin
          if (phase_cnt == RECOV_LAST) begin
            phase_cnt <= '0;
            if ((rows_left != '0) && !abort) begin
              // Row address wraps naturally at the top of the bank.
              sel       <= sel + 1'b1;
              rows_left <= rows_left - 1'b1;
              state     <= SETUP;
            end else begin
              // An abort landing on the very last recovery edge still counts.
              done       <= 1'b1;
              aborted    <= abort_seen | abort;
              abort_seen <= 1'b0;
              rows_left  <= '0;
              busy       <= 1'b0;
              req_ready  <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
            if (abort) begin
              rows_left  <= '0;
              abort_seen <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bank_wl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bank_wl_sequencer
//  Purpose  : Self-checking bench for bank_wl_sequencer. A timeline model
//             (burst start, per-row period, end cycle) predicts every output
//             each cycle; directed vectors pin literal values. A second
//             instance with a non-default phase split is checked for select
//             stability and period.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bank_wl_sequencer;

  localparam int W     = 10;
  localparam int S     = 1;
  localparam int PU    = 2;
  localparam int R     = 1;
  localparam int P     = S + PU + R;
  localparam int NROWS = 1 << W;

  localparam int W2  = 5;
  localparam int S2  = 3;
  localparam int PU2 = 1;
  localparam int R2  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          req_valid = 1'b0;
  logic [W-1:0]  req_row   = '0;
  logic [W-1:0]  req_len   = '0;
  logic          abort     = 1'b0;
  logic          req_ready, WL_enable, busy, done, aborted;
  logic [W-1:0]  sel, cur_row;

  logic          req_valid2 = 1'b0;
  logic [W2-1:0] req_row2   = '0;
  logic [W2-1:0] req_len2   = '0;
  logic          abort2     = 1'b0;
  logic          req_ready2, WL_enable2, busy2, done2, aborted2;
  logic [W2-1:0] sel2, cur_row2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bank_wl_sequencer #(
    .ADDR_W(W), .SETUP_CYC(S), .PULSE_CYC(PU), .RECOV_CYC(R)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_len(req_len), .abort(abort),
    .sel(sel), .WL_enable(WL_enable), .busy(busy),
    .cur_row(cur_row), .done(done), .aborted(aborted)
  );

  bank_wl_sequencer #(
    .ADDR_W(W2), .SETUP_CYC(S2), .PULSE_CYC(PU2), .RECOV_CYC(R2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_row(req_row2), .req_len(req_len2), .abort(abort2),
    .sel(sel2), .WL_enable(WL_enable2), .busy(busy2),
    .cur_row(cur_row2), .done(done2), .aborted(aborted2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model of the main instance ----------------
  // A burst occupies cycles [m_start, m_end]; cycle offset p within it gives
  // row p/P and phase p%P. Abort just pulls m_end in and blanks the pulse.
  int m_cyc   = 0;
  int m_start = 0;
  int m_end   = 0;
  int m_cut   = 0;
  int m_row0  = 0;
  bit m_act   = 1'b0;
  bit m_ab    = 1'b0;

  task automatic model_step();
    int c, o, ne;
    bit busy_c;
    c      = m_cyc;
    busy_c = m_act && (c >= m_start) && (c <= m_end);
    if (busy_c && abort) begin
      o = (c - m_start) % P;
      if (o < S + PU) begin
        ne = c + R;
        if (c + 1 < m_cut) m_cut = c + 1;
      end else begin
        ne = c + (P - 1 - o);
      end
      if (ne < m_end) m_end = ne;
      m_ab = 1'b1;
    end
    if (!busy_c && (c >= 1) && req_valid) begin
      m_act   = 1'b1;
      m_start = c + 1;
      m_row0  = int'(req_row);
      m_end   = c + (int'(req_len) + 1) * P;
      m_cut   = 32'h7fffffff;
      m_ab    = 1'b0;
    end
    m_cyc = c + 1;
  endtask

  task automatic model_expect(output int e_busy, output int e_wl, output int e_ready,
                              output int e_done, output int e_ab, output int e_sel);
    int n, p;
    n = m_cyc;
    if (m_act && (n >= m_start) && (n <= m_end)) begin
      p       = n - m_start;
      e_busy  = 1;
      e_ready = 0;
      e_done  = 0;
      e_ab    = 0;
      e_sel   = (m_row0 + p / P) % NROWS;
      e_wl    = ((p % P) >= S && (p % P) < S + PU && n < m_cut) ? 1 : 0;
    end else begin
      e_busy  = 0;
      e_wl    = 0;
      e_ready = (n >= 1) ? 1 : 0;
      e_done  = (m_act && n == m_end + 1) ? 1 : 0;
      e_ab    = (e_done == 1 && m_ab) ? 1 : 0;
      e_sel   = m_act ? (m_row0 + (m_end - m_start) / P) % NROWS : 0;
    end
  endtask

  // Model advances on every clock edge and restarts on reset.
  initial begin : p_model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cyc = 0;
        m_act = 1'b0;
        m_ab  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Compare process: every cycle outside reset, mid-cycle.
  initial begin : p_compare
    int e_busy, e_wl, e_ready, e_done, e_ab, e_sel;
    forever begin
      @(negedge clk);
      if (!rst) begin
        model_expect(e_busy, e_wl, e_ready, e_done, e_ab, e_sel);
        check("model req_ready", int'(req_ready), e_ready);
        check("model busy",      int'(busy),      e_busy);
        check("model WL_enable", int'(WL_enable), e_wl);
        check("model sel",       int'(sel),       e_sel);
        check("model cur_row",   int'(cur_row),   e_sel);
        check("model done",      int'(done),      e_done);
        check("model aborted",   int'(aborted),   e_ab);
      end
    end
  end

  // Second instance: sel frozen while WL is high and for two cycles after it falls.
  initial begin : p_stability
    logic [W2-1:0] prev_sel;
    logic          wl_d1, wl_d2;
    prev_sel = '0;
    wl_d1    = 1'b0;
    wl_d2    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wl_d1 = 1'b0;
        wl_d2 = 1'b0;
      end else if (WL_enable2 || wl_d1 || wl_d2) begin
        check("sweep sel stable", int'(sel2), int'(prev_sel));
      end
      prev_sel = sel2;
      wl_d2    = wl_d1;
      wl_d1    = WL_enable2;
    end
  end

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "time limit reached");
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input int row, input int len);
    req_valid = 1'b1;
    req_row   = W'(row);
    req_len   = W'(len);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int e_sel, input int e_wl, input int e_busy,
                            input int e_ready, input int e_done, input int e_ab);
    check({tag, " sel"},       int'(sel),       e_sel);
    check({tag, " cur_row"},   int'(cur_row),   e_sel);
    check({tag, " WL_enable"}, int'(WL_enable), e_wl);
    check({tag, " busy"},      int'(busy),      e_busy);
    check({tag, " req_ready"}, int'(req_ready), e_ready);
    check({tag, " done"},      int'(done),      e_done);
    check({tag, " aborted"},   int'(aborted),   e_ab);
  endtask

  initial begin : p_stim
    // Reset state
    adv(2);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    check("reset dut2 WL_enable", int'(WL_enable2), 0);
    check("reset dut2 req_ready", int'(req_ready2), 0);
    #1 rst = 1'b0;
    check("post-release req_ready before edge", int'(req_ready), 0);
    adv(1);
    expect_out("first edge", 0, 0, 0, 1, 0, 0);

    // Single row 5
    start(5, 0);
    expect_out("single c1", 5, 0, 1, 0, 0, 0);
    adv(1); expect_out("single c2", 5, 1, 1, 0, 0, 0);
    adv(1); expect_out("single c3", 5, 1, 1, 0, 0, 0);
    adv(1); expect_out("single c4", 5, 0, 1, 0, 0, 0);
    adv(1); expect_out("single c5", 5, 0, 0, 1, 1, 0);

    // Burst with wrap 1022..1
    start(1022, 3);
    expect_out("wrap c1",  1022, 0, 1, 0, 0, 0);
    adv(4); expect_out("wrap c5",  1023, 0, 1, 0, 0, 0);
    adv(4); expect_out("wrap c9",  0,    0, 1, 0, 0, 0);
    adv(4); expect_out("wrap c13", 1,    0, 1, 0, 0, 0);
    adv(1); expect_out("wrap c14", 1,    1, 1, 0, 0, 0);
    adv(2); expect_out("wrap c16", 1,    0, 1, 0, 0, 0);
    adv(1); expect_out("wrap c17", 1,    0, 0, 1, 1, 0);

    // Abort in first pulse cycle of row 2 of a 4-row burst
    start(0, 3);
    adv(9); expect_out("abort pulse c10", 2, 1, 1, 0, 0, 0);
    abort = 1'b1;
    adv(1); abort = 1'b0;
    expect_out("abort pulse c11", 2, 0, 1, 0, 0, 0);
    adv(1); expect_out("abort pulse c12", 2, 0, 0, 1, 1, 1);

    // Abort on the final recovery exit
    start(4, 0);
    adv(3); expect_out("abort recov c4", 4, 0, 1, 0, 0, 0);
    abort = 1'b1;
    adv(1); abort = 1'b0;
    expect_out("abort recov c5", 4, 0, 0, 1, 1, 1);

    // Abort in setup, then abort while idle is ignored
    start(6, 1);
    expect_out("abort setup c1", 6, 0, 1, 0, 0, 0);
    abort = 1'b1;
    adv(1); abort = 1'b0;
    expect_out("abort setup c2", 6, 0, 1, 0, 0, 0);
    adv(1); expect_out("abort setup c3", 6, 0, 0, 1, 1, 1);
    adv(1); abort = 1'b1;
    expect_out("idle abort c4", 6, 0, 0, 1, 0, 0);
    adv(1); abort = 1'b0;
    expect_out("idle abort c5", 6, 0, 0, 1, 0, 0);

    // Back-to-back: req_valid held, second request only taken in the done cycle
    req_valid = 1'b1; req_row = W'(7); req_len = '0;
    adv(1); req_row = W'(9);
    expect_out("b2b c1", 7, 0, 1, 0, 0, 0);
    adv(4); expect_out("b2b c5", 7, 0, 0, 1, 1, 0);
    adv(1); req_valid = 1'b0;
    expect_out("b2b c6", 9, 0, 1, 0, 0, 0);
    adv(4); expect_out("b2b c10", 9, 0, 0, 1, 1, 0);

    // Asynchronous reset while the word line is high
    start(12, 0);
    adv(1); expect_out("rst c2", 12, 1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 expect_out("rst async", 0, 0, 0, 0, 0, 0);
    #10 expect_out("rst held", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    adv(1); expect_out("rst release", 0, 0, 0, 1, 0, 0);

    // Full-bank burst from row 3, wrapping through 0 and ending at row 2
    start(3, NROWS - 1);
    expect_out("full c1", 3, 0, 1, 0, 0, 0);
    adv(NROWS * P - 1); expect_out("full last", 2, 0, 1, 0, 0, 0);
    adv(1); expect_out("full done", 2, 0, 0, 1, 1, 0);

    // Second instance: setup 3, pulse 1, recovery 2, period 6; rows 30, 31, 0
    req_valid2 = 1'b1; req_row2 = W2'(30); req_len2 = W2'(2);
    adv(1); req_valid2 = 1'b0;
    for (int n = 1; n <= 19; n++) begin
      check("sweep WL_enable", int'(WL_enable2), int'(n == 4 || n == 10 || n == 16));
      check("sweep sel", int'(sel2), (n <= 6) ? 30 : ((n <= 12) ? 31 : 0));
      check("sweep busy", int'(busy2), int'(n <= 18));
      check("sweep done", int'(done2), int'(n == 19));
      if (n < 19) adv(1);
    end
    check("sweep aborted", int'(aborted2), 0);
    check("sweep req_ready", int'(req_ready2), 1);

    adv(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
